// File: rtl/alu_pkg.sv
// Shared opcode and FSM state definitions for the registered ALU.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_ADDC = 4'd1,
    OP_SUB  = 4'd2,
    OP_SUBC = 4'd3,
    OP_CMP  = 4'd4,
    OP_AND  = 4'd5,
    OP_OR   = 4'd6,
    OP_EXOR = 4'd7,
    OP_TEST = 4'd8,
    OP_LSL  = 4'd9,
    OP_LSR  = 4'd10,
    OP_ROL  = 4'd11,
    OP_ROR  = 4'd12,
    OP_ASR  = 4'd13,
    OP_MOV  = 4'd14,
    OP_MUL  = 4'd15
  } alu_op_t;

  typedef logic [0:0] fsm_state_t;
  localparam fsm_state_t ST_IDLE = 1'b0;
  localparam fsm_state_t ST_MUL  = 1'b1;

endpackage

// File: rtl/alu_mul_seq.sv
// Iterative shift-add unsigned multiplier, one partial product per clock.
module alu_mul_seq #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_load,
  input  logic [WIDTH-1:0]   i_a,
  input  logic [WIDTH-1:0]   i_b,
  output logic [2*WIDTH-1:0] o_prod,
  output logic               o_done
);

  logic [2*WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0]   r_mplier;
  logic [2*WIDTH-1:0] r_acc;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_run;
  logic [2*WIDTH-1:0] w_acc_nxt;

  // Product and done are presented combinationally on the last step so the
  // parent can register them on the same edge that finishes the multiply.
  assign w_acc_nxt = r_acc + (r_mplier[0] ? r_mcand : '0);
  assign o_prod    = w_acc_nxt;
  assign o_done    = r_run && (r_cnt == CNT_W'(WIDTH - 1));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_run    <= 1'b0;
    end else if (i_load) begin
      r_mcand  <= {{WIDTH{1'b0}}, i_a};
      r_mplier <= i_b;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_run    <= 1'b1;
    end else if (r_run) begin
      r_acc    <= w_acc_nxt;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt + CNT_W'(1);
      if (o_done) r_run <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Registered RAT ALU with START/BUSY/DONE handshake and multi-cycle multiply.
// state   | meaning
// IDLE    | accepts START; single-cycle ops complete on the accept edge
// MUL     | shift-add multiply running, START ignored
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [3:0]       i_sel,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_cin,
  output logic [WIDTH-1:0] o_result,
  output logic [WIDTH-1:0] o_hi,
  output logic             o_c,
  output logic             o_z,
  output logic             o_busy,
  output logic             o_done
);

  fsm_state_t         r_state;
  logic [WIDTH-1:0]   r_result;
  logic [WIDTH-1:0]   r_hi;
  logic               r_c;
  logic               r_z;
  logic               r_done;

  alu_op_t            w_op;
  logic               w_accept;
  logic               w_is_mul;
  logic               w_mul_done;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH:0]     w_t;
  logic [WIDTH:0]     w_a_x;
  logic [WIDTH:0]     w_b_x;
  logic [WIDTH:0]     w_cin_x;

  assign w_op     = alu_op_t'(i_sel);
  assign w_accept = i_start && (r_state == ST_IDLE);
  assign w_is_mul = (w_op == OP_MUL);
  assign w_a_x    = {1'b0, i_a};
  assign w_b_x    = {1'b0, i_b};
  assign w_cin_x  = {{WIDTH{1'b0}}, i_cin};

  alu_mul_seq #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_mul (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_load (w_accept && w_is_mul),
    .i_a    (i_a),
    .i_b    (i_b),
    .o_prod (w_prod),
    .o_done (w_mul_done)
  );

  // Bit WIDTH of the extended result is the carry, or the borrow on subtracts.
  always_comb begin
    w_t = '0;
    case (w_op)
      OP_ADD:          w_t = w_a_x + w_b_x;
      OP_ADDC:         w_t = w_a_x + w_b_x + w_cin_x;
      OP_SUB, OP_CMP:  w_t = w_a_x - w_b_x;
      OP_SUBC:         w_t = w_a_x - w_b_x - w_cin_x;
      OP_AND, OP_TEST: w_t = {1'b0, i_a & i_b};
      OP_OR:           w_t = {1'b0, i_a | i_b};
      OP_EXOR:         w_t = {1'b0, i_a ^ i_b};
      OP_LSL:          w_t = {i_a, i_cin};
      OP_LSR:          w_t = {i_a[0], i_cin, i_a[WIDTH-1:1]};
      OP_ROL:          w_t = {i_a[WIDTH-1], i_a[WIDTH-2:0], i_a[WIDTH-1]};
      OP_ROR:          w_t = {i_a[0], i_a[0], i_a[WIDTH-1:1]};
      OP_ASR:          w_t = {i_a[0], i_a[WIDTH-1], i_a[WIDTH-1:1]};
      default:         w_t = '0;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= ST_IDLE;
      r_result <= '0;
      r_hi     <= '0;
      r_c      <= 1'b0;
      r_z      <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (r_state == ST_IDLE) begin
        if (w_accept) begin
          if (w_is_mul) begin
            r_state <= ST_MUL;
          end else begin
            r_done <= 1'b1;
            r_hi   <= '0;
            if (w_op == OP_MOV) begin
              r_result <= i_b;
            end else begin
              r_result <= w_t[WIDTH-1:0];
              r_c      <= w_t[WIDTH];
              r_z      <= (w_t[WIDTH-1:0] == '0);
            end
          end
        end
      end else if (w_mul_done) begin
        r_state  <= ST_IDLE;
        r_done   <= 1'b1;
        r_result <= w_prod[WIDTH-1:0];
        r_hi     <= w_prod[2*WIDTH-1:WIDTH];
        r_c      <= |w_prod[2*WIDTH-1:WIDTH];
        r_z      <= (w_prod == '0);
      end
    end
  end

  assign o_result = r_result;
  assign o_hi     = r_hi;
  assign o_c      = r_c;
  assign o_z      = r_z;
  assign o_busy   = (r_state == ST_MUL);
  assign o_done   = r_done;

endmodule

// File: tb/tb_alu_seq.sv
// Randomized bench for alu_seq (8- and 16-bit instances) against an arithmetic model.
module tb_alu_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  sel = '0;
  logic [7:0]  a = '0, b = '0;
  logic        cin = 1'b0;
  logic [7:0]  o_result, o_hi;
  logic        o_c, o_z, o_busy, o_done;

  logic        start16 = 1'b0;
  logic [3:0]  sel16 = '0;
  logic [15:0] a16 = '0, b16 = '0;
  logic        cin16 = 1'b0;
  logic [15:0] o_result16, o_hi16;
  logic        o_c16, o_z16, o_busy16, o_done16;

  int n_checks = 0;
  int n_errors = 0;

  longint unsigned m_res = 0, m_hi = 0, m16_res = 0, m16_hi = 0;
  bit m_c = 0, m_z = 0, m16_c = 0, m16_z = 0;

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(8)) dut8 (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_sel(sel), .i_a(a), .i_b(b),
    .i_cin(cin), .o_result(o_result), .o_hi(o_hi), .o_c(o_c), .o_z(o_z),
    .o_busy(o_busy), .o_done(o_done)
  );

  alu_seq #(.WIDTH(16)) dut16 (
    .i_clk(clk), .i_rst(rst), .i_start(start16), .i_sel(sel16), .i_a(a16), .i_b(b16),
    .i_cin(cin16), .o_result(o_result16), .o_hi(o_hi16), .o_c(o_c16), .o_z(o_z16),
    .o_busy(o_busy16), .o_done(o_done16)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Architectural meaning of each opcode, in plain integer arithmetic.
  task automatic ref_op(input int w, input logic [3:0] s, input longint unsigned xa,
                        input longint unsigned xb, input bit xc,
                        inout longint unsigned res, inout longint unsigned hi,
                        inout bit c, inout bit z);
    longint unsigned mask, msb, p;
    mask = (64'd1 << w) - 1;
    msb  = 64'd1 << (w - 1);
    hi   = 0;
    case (s)
      4'd0:       begin res = (xa + xb) & mask;      c = (xa + xb) > mask; end
      4'd1:       begin res = (xa + xb + xc) & mask; c = (xa + xb + xc) > mask; end
      4'd2, 4'd4: begin res = (xa - xb) & mask;      c = xa < xb; end
      4'd3:       begin res = (xa - xb - xc) & mask; c = xa < (xb + xc); end
      4'd5, 4'd8: begin res = xa & xb; c = 0; end
      4'd6:       begin res = xa | xb; c = 0; end
      4'd7:       begin res = xa ^ xb; c = 0; end
      4'd9:       begin res = ((xa << 1) | xc) & mask;       c = (xa & msb) != 0; end
      4'd10:      begin res = (xa >> 1) | (xc ? msb : 0);    c = xa[0]; end
      4'd11:      begin res = ((xa << 1) & mask) | ((xa & msb) != 0 ? 1 : 0); c = (xa & msb) != 0; end
      4'd12:      begin res = (xa >> 1) | (xa[0] ? msb : 0); c = xa[0]; end
      4'd13:      begin res = (xa >> 1) | (xa & msb);        c = xa[0]; end
      4'd14:      res = xb;
      default: begin
        p   = xa * xb;
        res = p & mask;
        hi  = p >> w;
        c   = hi != 0;
        z   = p == 0;
      end
    endcase
    if (s < 4'd14) z = (res == 0);
  endtask

  task automatic check_outs8(input string tag);
    check_eq({tag, "_res"}, o_result, m_res);
    check_eq({tag, "_hi"},  o_hi,     m_hi);
    check_eq({tag, "_c"},   o_c,      m_c);
    check_eq({tag, "_z"},   o_z,      m_z);
  endtask

  // One operation on the 8-bit DUT; inputs scramble while busy, optional ignored START mid-MUL.
  task automatic do_op(input logic [3:0] s, input logic [7:0] xa, input logic [7:0] xb,
                       input bit xc, input bit inject);
    int cyc;
    @(negedge clk);
    start = 1'b1; sel = s; a = xa; b = xb; cin = xc;
    ref_op(8, s, xa, xb, xc, m_res, m_hi, m_c, m_z);
    @(posedge clk); #1;
    start = 1'b0;
    if (s != 4'd15) begin
      check_eq("op_done", o_done, 1'b1);
      check_eq("op_busy", o_busy, 1'b0);
    end else begin
      check_eq("mul_busy", o_busy, 1'b1);
      cyc = 1;
      while (!o_done && cyc < 14) begin
        a = 8'($urandom); b = 8'($urandom); sel = 4'($urandom); cin = 1'($urandom);
        if (inject && cyc == 3) begin start = 1'b1; sel = 4'd0; a = 8'd1; b = 8'd1; end
        @(posedge clk); #1;
        start = 1'b0;
        if (!o_done) check_eq("mul_busy_hold", o_busy, 1'b1);
        else cyc = cyc;
        if (!o_done) cyc++;
      end
      check_eq("mul_latency", cyc, 8);
      check_eq("mul_busy_end", o_busy, 1'b0);
    end
    check_outs8("op");
  endtask

  task automatic do_op16(input logic [3:0] s, input logic [15:0] xa, input logic [15:0] xb,
                         input bit xc);
    int cyc;
    @(negedge clk);
    start16 = 1'b1; sel16 = s; a16 = xa; b16 = xb; cin16 = xc;
    ref_op(16, s, xa, xb, xc, m16_res, m16_hi, m16_c, m16_z);
    @(posedge clk); #1;
    start16 = 1'b0;
    cyc = 1;
    while (!o_done16 && cyc < 30) begin
      @(posedge clk); #1;
      if (!o_done16) cyc++;
    end
    check_eq("w16_latency", cyc, (s == 4'd15) ? 16 : 1);
    check_eq("w16_res", o_result16, m16_res);
    check_eq("w16_hi",  o_hi16,     m16_hi);
    check_eq("w16_c",   o_c16,      m16_c);
    check_eq("w16_z",   o_z16,      m16_z);
  endtask

  initial begin
    int dones;
    repeat (3) @(posedge clk);
    #1;
    check_outs8("reset");
    check_eq("reset_busy", o_busy, 1'b0);
    check_eq("reset_done", o_done, 1'b0);
    check_eq("reset_res16", o_result16, 16'h0);
    rst = 1'b0;

    do_op(4'd0, 8'hFF, 8'h01, 1'b0, 1'b0);
    @(posedge clk); #1;
    check_eq("add_done_pulse", o_done, 1'b0);
    check_eq("add_hold_res", o_result, m_res);

    do_op(4'd3, 8'h10, 8'h01, 1'b1, 1'b0);
    do_op(4'd4, 8'h01, 8'h02, 1'b0, 1'b0);

    do_op(4'd15, 8'hFF, 8'hFF, 1'b0, 1'b1);
    @(posedge clk); #1;
    check_eq("mul_no_extra_done", o_done, 1'b0);
    check_eq("mul_ignored_res", o_result, m_res);

    do_op(4'd0, 8'h80, 8'h80, 1'b0, 1'b0);
    do_op(4'd14, 8'h00, 8'h5A, 1'b0, 1'b0);
    do_op(4'd12, 8'h01, 8'h00, 1'b0, 1'b0);

    // Abort a multiply partway through with reset.
    @(negedge clk);
    start = 1'b1; sel = 4'd15; a = 8'hC3; b = 8'h5D; cin = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    m_res = 0; m_hi = 0; m_c = 0; m_z = 0;
    check_outs8("rst_mid");
    check_eq("rst_mid_busy", o_busy, 1'b0);
    check_eq("rst_mid_done", o_done, 1'b0);
    dones = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (o_done) dones++;
    end
    check_eq("rst_mid_no_done", dones, 0);
    do_op(4'd0, 8'h02, 8'h03, 1'b0, 1'b0);

    for (int i = 0; i < 80; i++)
      do_op(4'($urandom), 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
    for (int i = 0; i < 6; i++)
      do_op(4'($urandom_range(9, 13)), (i % 2 == 0) ? 8'h80 : 8'h01, 8'($urandom), 1'($urandom), 1'b0);
    do_op(4'd15, 8'h00, 8'h77, 1'b0, 1'b0);
    do_op(4'd2, 8'h00, 8'h00, 1'b0, 1'b0);

    do_op16(4'd15, 16'h1234, 16'h0010, 1'b0);
    do_op16(4'd13, 16'h8001, 16'h0000, 1'b0);
    for (int i = 0; i < 10; i++)
      do_op16(4'($urandom), 16'($urandom), 16'($urandom), 1'($urandom));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, registered successor to the 8-bit combinational ALU for the RAT MCU datapath.
- Operand width is WIDTH bits. All results and the C and Z flags are registered.
- Adds a START/BUSY/DONE handshake and a multi-cycle unsigned multiply (SEL=15).
- Sits between the register file and the flag/result write-back. The control unit launches an op with START and waits for DONE.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 4..32.
- CNT_W, $clog2(WIDTH+1), width of the multiply iteration counter; derived, do not override.

Ports:
- CLK  in  1  clock; all state changes on the rising edge.
- RST  in  1  synchronous, active-high reset.
- START  in  1  launch request; sampled only when BUSY=0.
- SEL  in  4  opcode, captured on an accepted START.
- A  in  WIDTH  operand A, captured on an accepted START.
- B  in  WIDTH  operand B, captured on an accepted START.
- CIN  in  1  carry-in, captured on an accepted START.
- RESULT  out  WIDTH  registered result; held until the next DONE.
- HI  out  WIDTH  upper half of the MUL product; 0 for all other ops.
- C  out  1  registered carry/borrow flag.
- Z  out  1  registered zero flag.
- BUSY  out  1  high while a MUL is in progress.
- DONE  out  1  one-cycle pulse; RESULT, HI and flags are valid from this cycle.

Behaviour:
- Reset (RST=1 at an edge): RESULT=0, HI=0, C=0, Z=0, BUSY=0, DONE=0, FSM=IDLE. Reset aborts an in-flight MUL with no DONE.
- Accept rule: START=1 with BUSY=0 is accepted. START while BUSY=1 is ignored and not queued.
- FSM states:
  - IDLE: an accepted START with SEL≠15 executes the op at the same edge. RESULT and flags register, DONE=1 next cycle, FSM stays IDLE.
  - IDLE → MUL: an accepted START with SEL=15 loads the multiplicand, multiplier and product accumulator, clears the counter, sets BUSY=1.
  - MUL: one shift-add step per edge for WIDTH edges. At the WIDTH-th step edge: product registered, DONE=1, BUSY=0, back to IDLE.
- Latency:
  - Single-cycle ops: DONE in the cycle after the accept edge.
  - MUL: DONE WIDTH cycles after the accept edge.
- Back-to-back: START may be high in the same cycle as DONE. In IDLE it is accepted, giving a DONE every cycle for single-cycle ops.
- Opcodes: N=WIDTH. The core uses an (N+1)-bit intermediate t. RESULT=t[N-1:0]. For ops 0–14, C=t[N].
  - 0 ADD: A+B
  - 1 ADDC: A+B+CIN
  - 2 SUB: A−B (C=borrow)
  - 3 SUBC: A−B−CIN
  - 4 CMP: as SUB
  - 5 AND: t={0,A&B}
  - 6 OR: t={0,A|B}
  - 7 EXOR: t={0,A^B}
  - 8 TEST: as AND
  - 9 LSL: t={A,CIN}
  - 10 LSR: t={A[0],CIN,A[N-1:1]}
  - 11 ROL: t={A[N-1],A[N-2:0],A[N-1]}
  - 12 ROR: t={A[0],A[0],A[N-1:1]}
  - 13 ASR: t={A[0],A[N-1],A[N-1:1]}
  - 14 MOV: RESULT=B
  - 15 MUL: unsigned A×B, 2N-bit product {HI,RESULT}
- Flag rules:
  - Z=(RESULT==0) for ops 0–13.
  - MOV: C and Z unchanged.
  - MUL: C=(HI≠0), Z=(full 2N-bit product==0).
- Flags and RESULT/HI update only on a DONE edge; otherwise they hold.
- Width rules: all arithmetic is unsigned and modulo 2^N. The borrow from SUB/SUBC/CMP is bit N of the (N+1)-bit difference.
- Operands are captured at accept. Changing A, B, SEL or CIN during BUSY has no effect.

Decomposition:
- Package alu_pkg:
  - enum alu_op_t (ADD…MOV, MUL; 4-bit, values 0–15).
  - fsm_state_t (IDLE, MUL).
- Sub-module alu_mul_seq: iterative shift-add multiplier.
  - Ports: CLK, RST, LOAD, A, B, PROD (2·WIDTH), DONE.
  - Parametrised by WIDTH.
  - alu_seq instantiates it and muxes its output into RESULT/HI.

Test Plan (WIDTH=8 unless noted):
- ADD, A=0xFF, B=0x01, START one cycle → DONE next cycle; RESULT=0x00, C=1, Z=1; BUSY never asserted.
- SUBC, A=0x10, B=0x01, CIN=1 → RESULT=0x0E, C=0, Z=0. Then CMP A=0x01, B=0x02 → RESULT=0xFF, C=1.
- MUL, A=0xFF, B=0xFF → BUSY high 8 cycles; DONE exactly 8 cycles after accept; RESULT=0x01, HI=0xFE, C=1, Z=0. A second START mid-MUL (ADD 1+1) is ignored: RESULT stays 0x01 and no extra DONE.
- Flags persistence: ADD 0x80+0x80 (C=1, Z=1), then MOV B=0x5A → RESULT=0x5A, C=1, Z=1 unchanged. Then ROR A=0x01 → RESULT=0x80, C=1, Z=0.
- Reset mid-MUL: RST high at the 4th MUL cycle → next cycle all outputs 0, BUSY=0, no DONE. A fresh ADD 2+3 afterwards → RESULT=0x05 one cycle after accept.
- WIDTH=16, MUL A=0x1234, B=0x0010 → DONE after 16 cycles; RESULT=0x2340, HI=0x0001, C=1. Then ASR A=0x8001 → RESULT=0xC000, C=1.
